// File: rtl/summator_seq.sv
// Window sequencer for an external summator accumulator: clears it, streams
// len samples through the A/ce handshake, lets the last sample settle and captures the sum.
module summator_seq #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [12:0]      s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [12:0]      acc_a,
   output logic             acc_ce,
   output logic             acc_rst,
   input  logic [20:0]      acc_y,
   output logic [20:0]      result,
   output logic             done,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      CLEAR,
      RUN,
      DRAIN,
      CAPTURE
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] count;
   logic [LEN_W-1:0] count_nxt;
   logic             xfer;

   assign xfer      = s_ready & s_valid;
   assign count_nxt = count + LEN_W'(1);

   // ce follows s_valid in the same cycle; A is forced to zero whenever ce is low
   assign acc_ce  = xfer;
   assign acc_a   = acc_ce ? s_data : 13'd0;
   assign acc_rst = rst | (state == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         len_q   <= '0;
         count   <= '0;
         result  <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         s_ready <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (len != '0)) begin
                  len_q <= len;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               state <= CLEAR;
            end
            CLEAR: begin
               s_ready <= 1'b1;
               state   <= RUN;
            end
            RUN: begin
               if (xfer) begin
                  count <= count_nxt;
                  if (count_nxt == len_q) begin
                     s_ready <= 1'b0;
                     state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               result <= acc_y;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               s_ready <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_summator_seq.sv
// Directed bench for summator_seq; a behavioural summator (registered A,
// sum += registered A, sync clear) closes the loop on acc_y.
module tb_summator_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic [12:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [12:0] acc_a;
   logic        acc_ce;
   logic        acc_rst;
   logic [20:0] acc_y;
   logic [20:0] result;
   logic        done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int dbl = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   summator_seq #(.LEN_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .len     (len),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .acc_a   (acc_a),
      .acc_ce  (acc_ce),
      .acc_rst (acc_rst),
      .acc_y   (acc_y),
      .result  (result),
      .done    (done),
      .busy    (busy)
   );

   // downstream summator: one register on A, then accumulate
   logic [12:0] m_a = 13'd0;
   logic [20:0] m_y = 21'd0;
   always @(posedge clk) begin
      m_a <= acc_a;
      if (acc_rst) m_y <= 21'd0;
      else         m_y <= m_y + {{8{m_a[12]}}, m_a};
   end
   assign acc_y = m_y;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (done && prev_done) dbl <= dbl + 1;
      prev_done <= done;
   end

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input int n);
      start = 1'b1;
      len   = 8'(n);
      tick;
      start = 1'b0;
   endtask

   task automatic send(input logic [12:0] d);
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 10 && !s_ready; i++) tick;
      if (!s_ready) begin
         checks++;
         errors++;
         $error("FAIL send_ready observed=s_ready_low expected=s_ready_high");
      end
      tick;
      s_valid = 1'b0;
      s_data  = 13'd0;
   endtask

   task automatic wait_done(input string tag);
      int i;
      i = 0;
      while (!done && i < 600) begin
         tick;
         i++;
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL %s observed=no_done expected=done", tag);
      end
   endtask

   initial begin
      int t0;
      int xfer_cyc;
      int dc0;

      rst = 1'b1; start = 1'b0; len = 8'd0; s_data = 13'd0; s_valid = 1'b0;
      tick;
      tick;
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", s_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 21'd0);
      chk("rst_acc_rst", acc_rst, 1'b1);
      chk("rst_acc_ce", acc_ce, 1'b0);
      rst = 1'b0;
      tick;
      chk("idle_acc_rst", acc_rst, 1'b0);

      // basic window: len 3, samples 1,2,3
      t0 = cyc;
      go(3);
      chk("flush_busy", busy, 1'b1);
      chk("flush_acc_rst", acc_rst, 1'b0);
      chk("flush_ready", s_ready, 1'b0);
      tick;
      chk("clear_acc_rst", acc_rst, 1'b1);
      chk("clear_ce", acc_ce, 1'b0);
      tick;
      chk("run_ready", s_ready, 1'b1);
      chk("run_cycle", cyc - t0, 3);
      s_valid = 1'b1;
      s_data  = 13'd1;
      #1;
      chk("run_ce", acc_ce, 1'b1);
      chk("run_a", acc_a, 13'd1);
      send(13'd1);
      send(13'd2);
      send(13'd3);
      chk("drain_ready", s_ready, 1'b0);
      chk("drain_busy", busy, 1'b1);
      wait_done("basic_done");
      chk("basic_latency", cyc - t0, 8);
      chk("basic_result", result, 21'd6);
      tick;
      chk("basic_done_pulse", done, 1'b0);
      chk("basic_hold", result, 21'd6);
      chk("basic_idle", busy, 1'b0);

      // negative samples
      go(2);
      send(13'h1000);
      send(13'h1FFF);
      wait_done("neg_done");
      chk("neg_result", result, 21'h1FEFFF);

      // bubbles: valid 1,0,0,1
      go(2);
      send(13'd10);
      s_data = 13'd99;
      #1;
      chk("bubble_ce", acc_ce, 1'b0);
      chk("bubble_a", acc_a, 13'd0);
      tick;
      tick;
      chk("bubble_ready", s_ready, 1'b1);
      send(13'h1FFD);
      xfer_cyc = cyc - 1;
      wait_done("bubble_done");
      chk("bubble_latency", cyc - xfer_cyc, 3);
      chk("bubble_result", result, 21'd7);

      // reset in the middle of RUN
      go(4);
      send(13'd100);
      send(13'd200);
      s_valid = 1'b1;
      s_data  = 13'd300;
      rst = 1'b1;
      #1;
      chk("midrst_acc_rst", acc_rst, 1'b1);
      tick;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", s_ready, 1'b0);
      chk("midrst_result", result, 21'd0);
      rst = 1'b0;
      s_valid = 1'b0;
      s_data = 13'd0;
      dc0 = done_cnt;
      repeat (10) tick;
      chk("midrst_no_done", done_cnt, dc0);
      go(1);
      send(13'd7);
      wait_done("after_rst_done");
      chk("after_rst_result", result, 21'd7);

      // maximum length windows
      go(255);
      for (int i = 0; i < 255; i++) send(13'd4095);
      wait_done("max_pos_done");
      chk("max_pos_result", result, 21'd1044225);
      go(255);
      for (int i = 0; i < 255; i++) send(13'h1000);
      wait_done("max_neg_done");
      chk("max_neg_result", result, 21'h101000);

      // start while busy is ignored
      t0 = cyc;
      go(3);
      start = 1'b1;
      len   = 8'd2;
      tick;
      start = 1'b0;
      send(13'd1);
      send(13'd1);
      send(13'd1);
      wait_done("busy_start_done");
      chk("busy_start_latency", cyc - t0, 8);
      chk("busy_start_result", result, 21'd3);

      // len = 0 is ignored
      tick;
      dc0 = done_cnt;
      go(0);
      chk("len0_busy", busy, 1'b0);
      chk("len0_ready", s_ready, 1'b0);
      repeat (5) tick;
      chk("len0_no_done", done_cnt, dc0);
      chk("len0_result", result, 21'd3);

      // back-to-back start in the done cycle
      go(2);
      send(13'd4);
      send(13'd5);
      wait_done("b2b_first_done");
      chk("b2b_first_result", result, 21'd9);
      go(1);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_done_low", done, 1'b0);
      send(13'h1FFB);
      wait_done("b2b_second_done");
      chk("b2b_second_result", result, 21'h1FFFFB);
      tick;

      chk("done_double", dbl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/summator_seq.md
SUMMATOR_SEQ -- requirements
Module: summator_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter LEN_W, default 8: width of the window-length input; legal range 1..8, so a 21-bit signed sum cannot overflow.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1: request to run one accumulation window.
REQ-005 The block SHALL have port len, input, LEN_W: number of samples in the window, sampled with start.
REQ-006 The block SHALL have port s_data, input, 13: signed two's-complement sample.
REQ-007 The block SHALL have ports s_valid (input, 1) and s_ready (output, 1): sample handshake; transfer when both are high on a rising edge.
REQ-008 The block SHALL have ports acc_a (output, 13), acc_ce (output, 1) and acc_rst (output, 1): drive the A, ce and rst inputs of the downstream summator accumulator.
REQ-009 The block SHALL have port acc_y, input, 21: running sum from the summator.
REQ-010 The block SHALL have ports result (output, 21), done (output, 1) and busy (output, 1): captured window sum, one-cycle completion pulse, and window-in-progress flag.

Function
REQ-011 The block SHALL implement the states IDLE, FLUSH, CLEAR, RUN, DRAIN and CAPTURE.
REQ-012 IDLE: start=1 with len!=0 SHALL latch len and go to FLUSH; start with len=0 SHALL be ignored.
REQ-013 FLUSH (1 cycle): acc_ce=0 and acc_rst=0, which zeroes the summator's registered operand; then go to CLEAR.
REQ-014 CLEAR (1 cycle): acc_rst=1 and acc_ce=0, which zeroes the summator sum; then go to RUN.
REQ-015 RUN: s_ready=1; acc_a=s_data; acc_ce=s_valid (combinational); each transfer SHALL increment an internal count.
REQ-016 RUN: the transfer that makes count equal to the latched len SHALL move to DRAIN; s_valid=0 cycles are bubbles and SHALL NOT count.
REQ-017 DRAIN (1 cycle): acc_ce=0, which lets the summator fold in the last sample; then go to CAPTURE.
REQ-018 CAPTURE (1 cycle): load result<=acc_y, set done<=1 for exactly the next cycle, and go to IDLE.
REQ-019 The block SHALL drive s_ready=0 and acc_ce=0 in every state other than RUN.
REQ-020 When acc_ce=0, acc_a SHALL be 0.
REQ-021 busy SHALL be 1 in FLUSH, CLEAR, RUN, DRAIN and CAPTURE, and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no queueing.
REQ-023 With no bubbles, done SHALL assert len+5 cycles after the start cycle.
REQ-024 result SHALL hold its value until the next CAPTURE; done SHALL never be high for two consecutive cycles.
REQ-025 result SHALL equal the exact signed sum of the len accepted samples, sign-extended from 13 to 21 bits, with no saturation.
REQ-026 done may coincide with a new start in the same cycle; that start SHALL be accepted because the state is IDLE.

Reset
REQ-027 With rst=1 on a rising edge, the block SHALL enter IDLE, with count=0, result=0, done=0, busy=0 and s_ready=0.
REQ-028 acc_rst SHALL be 1 for every cycle in which rst=1, so the summator clears together with the sequencer.
REQ-029 rst mid-window (any state) SHALL abandon the window with no done pulse; the next window SHALL pass through FLUSH/CLEAR again, so no stale partial sum survives.

Verification
REQ-030 Bench case, basic window: start with len=3 at cycle 0, s_valid held high, samples 1, 2, 3 -> transfers in cycles 3-5; done=1 only in cycle 8, with result=6.
REQ-031 Bench case, negative samples: len=2, samples -4096 and -1 -> result=21'h1FEFFF (-4097).
REQ-032 Bench case, bubbles: len=2, s_valid pattern 1,0,0,1 in RUN -> exactly 2 transfers; done 3 cycles after the second transfer, with the correct sum.
REQ-033 Bench case, reset mid-RUN after 2 of 4 samples, then a new window with len=1 and sample 7 -> the first window produces no done; the second window gives result=7, independent of the abandoned partial sum.
REQ-034 Bench case, maximum length: len=255, every sample 4095 -> result=1044225; then len=255, every sample -4096 -> result=-1044480 (21'h101000).
REQ-035 Bench case, ignored requests: start while busy, and start with len=0 while idle -> no state change and no extra done pulse; back-to-back start in the done cycle -> the second window completes normally.
